// File: rtl/swd_xfer_seq.sv
// SWD transfer sequencer: launches one DP/AP access on the bit engine, retries WAIT after back-off.
// Optional SWD_SEQ_STICKY_FAULT_EN: a FAULT ack blocks launches until a DP ABORT write is accepted.
module swd_xfer_seq #(
    parameter int RETRY_W = 8,
    parameter int BACKOFF = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RETRY_W-1:0] retry_limit,
    input  logic               abort,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_addr32,
    input  logic               cmd_rnw,
    input  logic               cmd_apndp,
    input  logic [31:0]        cmd_wdata,
    output logic [1:0]         eng_addr32,
    output logic               eng_rnw,
    output logic               eng_apndp,
    output logic [31:0]        eng_dwrite,
    output logic               eng_go,
    input  logic               eng_idle,
    input  logic [2:0]         eng_ack,
    input  logic [31:0]        eng_dread,
    input  logic               eng_perr,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2:0]         rsp_ack,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_perr,
    output logic [RETRY_W-1:0] rsp_retries
);
    localparam int CNT_W = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
    localparam logic [2:0] ACK_OK   = 3'b001;
    localparam logic [2:0] ACK_WAIT = 3'b010;

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_BUSY, S_BACKOFF, S_DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [RETRY_W-1:0] left;
    logic [CNT_W-1:0]   bo_cnt;
    logic               busy_first;
    logic               accept;
    logic               complete;
    logic               retry;
    logic               go_next;
    logic               skip_launch;

    assign accept = cmd_valid && cmd_ready;

`ifdef SWD_SEQ_STICKY_FAULT_EN
    localparam logic [2:0] ACK_FAULT = 3'b100;
    logic sticky;
    logic dp_abort;

    assign dp_abort    = !cmd_rnw && !cmd_apndp && (cmd_addr32 == 2'd0);
    assign skip_launch = sticky && !dp_abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sticky <= 1'b0;
        else if (accept && dp_abort)
            sticky <= 1'b0;
        else if (complete && eng_ack == ACK_FAULT)
            sticky <= 1'b1;
    end
`else
    assign skip_launch = 1'b0;
`endif

    // eng_go is registered: it is decided from eng_idle one cycle ahead, and
    // the engine cannot leave idle without a go, so idle still holds when it fires.
    always_comb begin
        state_next = state;
        go_next    = 1'b0;
        complete   = 1'b0;
        retry      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (skip_launch) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_LAUNCH;
                        go_next    = eng_idle;
                    end
                end
            end
            S_LAUNCH: begin
                if (eng_go)
                    state_next = S_BUSY;
                else
                    go_next = eng_idle;
            end
            S_BUSY: begin
                if (!busy_first && eng_idle) begin
                    complete = 1'b1;
                    if (eng_ack == ACK_WAIT && left != '0) begin
                        retry      = 1'b1;
                        state_next = S_BACKOFF;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_BACKOFF: begin
                if (abort) begin
                    state_next = S_DONE;
                end else if (bo_cnt == '0) begin
                    state_next = S_LAUNCH;
                    go_next    = eng_idle;
                end
            end
            S_DONE: begin
                if (rsp_ready)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            eng_go      <= 1'b0;
            busy_first  <= 1'b0;
            left        <= '0;
            bo_cnt      <= '0;
            eng_addr32  <= '0;
            eng_rnw     <= 1'b0;
            eng_apndp   <= 1'b0;
            eng_dwrite  <= '0;
            rsp_ack     <= '0;
            rsp_rdata   <= '0;
            rsp_perr    <= 1'b0;
            rsp_retries <= '0;
        end else begin
            state      <= state_next;
            cmd_ready  <= (state_next == S_IDLE);
            rsp_valid  <= (state_next == S_DONE);
            eng_go     <= go_next;
            busy_first <= (state == S_LAUNCH);

            if (accept) begin
                eng_addr32  <= cmd_addr32;
                eng_rnw     <= cmd_rnw;
                eng_apndp   <= cmd_apndp;
                eng_dwrite  <= cmd_wdata;
                left        <= retry_limit;
                rsp_retries <= '0;
                rsp_ack     <= skip_launch ? 3'b100 : 3'b000;
                rsp_rdata   <= '0;
                rsp_perr    <= 1'b0;
            end

            if (complete) begin
                rsp_ack   <= eng_ack;
                rsp_rdata <= (eng_rnw && eng_ack == ACK_OK) ? eng_dread : '0;
                rsp_perr  <= eng_perr && eng_rnw;
            end

            if (retry) begin
                left        <= left - RETRY_W'(1);
                rsp_retries <= rsp_retries + RETRY_W'(1);
                bo_cnt      <= CNT_W'(BACKOFF - 1);
            end else if (state == S_BACKOFF && bo_cnt != '0) begin
                bo_cnt <= bo_cnt - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_swd_xfer_seq.sv
// Directed bench for swd_xfer_seq: scripted engine model plus a response scoreboard.
// Honours SWD_SEQ_STICKY_FAULT_EN for the sticky-fault steps.
module tb_swd_xfer_seq;
    localparam int RETRY_W = 8;
    localparam int BACKOFF = 16;
    localparam int LAT     = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [RETRY_W-1:0] retry_limit;
    logic               abort;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_addr32;
    logic               cmd_rnw;
    logic               cmd_apndp;
    logic [31:0]        cmd_wdata;
    logic [1:0]         eng_addr32;
    logic               eng_rnw;
    logic               eng_apndp;
    logic [31:0]        eng_dwrite;
    logic               eng_go;
    logic               eng_idle;
    logic [2:0]         eng_ack;
    logic [31:0]        eng_dread;
    logic               eng_perr;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [2:0]         rsp_ack;
    logic [31:0]        rsp_rdata;
    logic               rsp_perr;
    logic [RETRY_W-1:0] rsp_retries;

    swd_xfer_seq #(.RETRY_W(RETRY_W), .BACKOFF(BACKOFF)) dut (
        .clk(clk), .rst(rst), .retry_limit(retry_limit), .abort(abort),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr32(cmd_addr32),
        .cmd_rnw(cmd_rnw), .cmd_apndp(cmd_apndp), .cmd_wdata(cmd_wdata),
        .eng_addr32(eng_addr32), .eng_rnw(eng_rnw), .eng_apndp(eng_apndp),
        .eng_dwrite(eng_dwrite), .eng_go(eng_go), .eng_idle(eng_idle),
        .eng_ack(eng_ack), .eng_dread(eng_dread), .eng_perr(eng_perr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ack(rsp_ack),
        .rsp_rdata(rsp_rdata), .rsp_perr(rsp_perr), .rsp_retries(rsp_retries)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  ack;
        logic [31:0] rdata;
        logic        perr;
        logic [7:0]  retries;
        int          launches;
        bit          timed;
        int          acc;
    } exp_t;
    exp_t exp_q[$];

    // engine model: scripted results, completes LAT cycles after each go
    logic [2:0]  scr_ack[$];
    logic [31:0] scr_data[$];
    logic        scr_perr[$];
    int          go_q[$];
    int          comp_q[$];
    int          nlaunch = 0;
    int          ecnt = 0;
    logic        prev_go = 1'b0;
    logic [1:0]  cur_addr;
    logic        cur_rnw;
    logic        cur_apndp;
    logic [31:0] cur_wdata;

    always begin
        @(posedge clk);
        #1;
        if (eng_go) begin
            chk("go_rules", {62'd0, prev_go, eng_idle}, 64'd1);
            chk("go_fields", {28'd0, eng_addr32, eng_rnw, eng_apndp, eng_dwrite},
                {28'd0, cur_addr, cur_rnw, cur_apndp, cur_wdata});
            go_q.push_back(cyc);
            nlaunch++;
            ecnt = LAT;
        end else if (ecnt > 1) begin
            eng_idle = 1'b0;
            ecnt--;
        end else if (ecnt == 1) begin
            ecnt = 0;
            eng_idle = 1'b1;
            if (scr_ack.size() > 0) begin
                eng_ack   = scr_ack.pop_front();
                eng_dread = scr_data.pop_front();
                eng_perr  = scr_perr.pop_front();
            end else begin
                eng_ack   = 3'b111;
                eng_dread = 32'hBAD0BAD0;
                eng_perr  = 1'b0;
            end
            comp_q.push_back(cyc);
        end
        prev_go = eng_go;
    end

    task automatic script(input logic [2:0] a, input logic [31:0] d, input logic p);
        scr_ack.push_back(a);
        scr_data.push_back(d);
        scr_perr.push_back(p);
    endtask

    task automatic push_exp(input logic [2:0] a, input logic [31:0] d, input logic p,
                            input logic [7:0] r, input int l, input bit timed, input int acc);
        exp_t e;
        e.ack = a; e.rdata = d; e.perr = p; e.retries = r;
        e.launches = l; e.timed = timed; e.acc = acc;
        exp_q.push_back(e);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ctl"}, {49'd0, cmd_ready, eng_go, rsp_valid, rsp_ack, rsp_perr, rsp_retries},
            {49'd0, 1'b1, 14'd0});
        chk({tag, "_rdata"}, {32'd0, rsp_rdata}, 64'd0);
        chk({tag, "_eng"}, {28'd0, eng_addr32, eng_rnw, eng_apndp, eng_dwrite}, 64'd0);
    endtask

    task automatic send_cmd(input logic [1:0] a, input logic rnw, input logic ap,
                            input logic [31:0] wd, input logic [7:0] lim, output int acc);
        @(negedge clk);
        chk("cmd_ready", {63'd0, cmd_ready}, 64'd1);
        go_q.delete();
        comp_q.delete();
        nlaunch = 0;
        cur_addr = a; cur_rnw = rnw; cur_apndp = ap; cur_wdata = wd;
        cmd_addr32 = a; cmd_rnw = rnw; cmd_apndp = ap; cmd_wdata = wd;
        retry_limit = lim;
        cmd_valid = 1'b1;
        acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr32 = ~a; cmd_rnw = ~rnw; cmd_apndp = ~ap; cmd_wdata = ~wd;
        retry_limit = 8'hFF;
    endtask

    task automatic wait_rsp(input int hold);
        exp_t e;
        int n = 0;
        int rv;
        logic [44:0] snap;
        bit stable = 1'b1;
        while (!rsp_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        chk("rsp_arrived", {63'd0, rsp_valid}, 64'd1);
        if (!rsp_valid) return;
        rv = cyc;
        chk("rsp_ack", {61'd0, rsp_ack}, {61'd0, e.ack});
        chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
        chk("rsp_perr", {63'd0, rsp_perr}, {63'd0, e.perr});
        chk("rsp_retries", {56'd0, rsp_retries}, {56'd0, e.retries});
        chk("launches", 64'(nlaunch), 64'(e.launches));
        chk("ready_vs_valid", {63'd0, cmd_ready}, 64'd0);
        if (e.timed && comp_q.size() > 0)
            chk("rsp_latency", 64'(rv), 64'(comp_q[comp_q.size()-1] + 1));
        if (e.launches == 0)
            chk("skip_latency", 64'(rv), 64'(e.acc + 1));
        if (go_q.size() > 0)
            chk("go_first", 64'(go_q[0]), 64'(e.acc + 1));
        for (int i = 1; i < go_q.size(); i++)
            chk("go_gap", 64'(go_q[i]), 64'(comp_q[i-1] + BACKOFF + 1));
        if (hold > 0) begin
            snap = {rsp_valid, rsp_ack, rsp_rdata, rsp_perr, rsp_retries};
            cmd_valid = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if ({rsp_valid, rsp_ack, rsp_rdata, rsp_perr, rsp_retries} !== snap || cmd_ready !== 1'b0)
                    stable = 1'b0;
            end
            cmd_valid = 1'b0;
            chk("hold_stable", {63'd0, stable}, 64'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_release", {62'd0, rsp_valid, cmd_ready}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int n;
        bit quiet;
        rst = 1'b1; abort = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_addr32 = '0; cmd_rnw = 1'b0; cmd_apndp = 1'b0; cmd_wdata = '0; retry_limit = '0;
        eng_idle = 1'b1; eng_ack = 3'b000; eng_dread = '0; eng_perr = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset("post_reset");

        // plain DP read; abort during BUSY must be ignored
        script(3'b001, 32'h2BA01477, 1'b0);
        send_cmd(2'd0, 1'b1, 1'b0, 32'h0, 8'd3, acc);
        push_exp(3'b001, 32'h2BA01477, 1'b0, 8'd0, 1, 1'b1, acc);
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        wait_rsp(0);

        // AP write, WAIT WAIT OK
        script(3'b010, 32'h11111111, 1'b0);
        script(3'b010, 32'h22222222, 1'b0);
        script(3'b001, 32'h33333333, 1'b0);
        send_cmd(2'd1, 1'b0, 1'b1, 32'hA5A5A5A5, 8'd3, acc);
        push_exp(3'b001, 32'h0, 1'b0, 8'd2, 3, 1'b1, acc);
        wait_rsp(0);

        // retries exhausted
        repeat (3) script(3'b010, 32'h44444444, 1'b0);
        send_cmd(2'd1, 1'b1, 1'b0, 32'h0, 8'd2, acc);
        push_exp(3'b010, 32'h0, 1'b0, 8'd2, 3, 1'b1, acc);
        wait_rsp(0);

        // abort during back-off
        script(3'b010, 32'h55555555, 1'b0);
        send_cmd(2'd2, 1'b1, 1'b1, 32'h0, 8'd3, acc);
        push_exp(3'b010, 32'h0, 1'b0, 8'd1, 1, 1'b0, acc);
        n = 0;
        while (comp_q.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_wait", {63'd0, comp_q.size() > 0}, 64'd1);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_rsp(0);

        // read with parity error, response back-pressured
        script(3'b001, 32'hDEADBEEF, 1'b1);
        send_cmd(2'd3, 1'b1, 1'b1, 32'h0, 8'd1, acc);
        push_exp(3'b001, 32'hDEADBEEF, 1'b1, 8'd0, 1, 1'b1, acc);
        wait_rsp(20);

        // write with WAIT and retries disabled: perr masked
        script(3'b010, 32'h66666666, 1'b1);
        send_cmd(2'd2, 1'b0, 1'b0, 32'h12345678, 8'd0, acc);
        push_exp(3'b010, 32'h0, 1'b0, 8'd0, 1, 1'b1, acc);
        wait_rsp(0);

        // FAULT read: data suppressed
        script(3'b100, 32'hCAFEF00D, 1'b0);
        send_cmd(2'd3, 1'b1, 1'b1, 32'h0, 8'd2, acc);
        push_exp(3'b100, 32'h0, 1'b0, 8'd0, 1, 1'b1, acc);
        wait_rsp(0);

`ifdef SWD_SEQ_STICKY_FAULT_EN
        send_cmd(2'd1, 1'b1, 1'b1, 32'h0, 8'd2, acc);
        push_exp(3'b100, 32'h0, 1'b0, 8'd0, 0, 1'b0, acc);
        wait_rsp(0);
`else
        script(3'b001, 32'h0BADF00D, 1'b0);
        send_cmd(2'd1, 1'b1, 1'b1, 32'h0, 8'd2, acc);
        push_exp(3'b001, 32'h0BADF00D, 1'b0, 8'd0, 1, 1'b1, acc);
        wait_rsp(0);
`endif

        // DP ABORT write always launches
        script(3'b001, 32'h0, 1'b0);
        send_cmd(2'd0, 1'b0, 1'b0, 32'h0000001E, 8'd0, acc);
        push_exp(3'b001, 32'h0, 1'b0, 8'd0, 1, 1'b1, acc);
        wait_rsp(0);

        // reset while BUSY: transfer dropped, no response
        script(3'b001, 32'h77777777, 1'b0);
        send_cmd(2'd1, 1'b1, 1'b0, 32'h0, 8'd2, acc);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst_busy");
        rst = 1'b0;
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || eng_go !== 1'b0) quiet = 1'b0;
        end
        chk("rst_drop", {63'd0, quiet}, 64'd1);

        script(3'b001, 32'h89ABCDEF, 1'b0);
        send_cmd(2'd2, 1'b1, 1'b0, 32'h0, 8'd1, acc);
        push_exp(3'b001, 32'h89ABCDEF, 1'b0, 8'd0, 1, 1'b1, acc);
        wait_rsp(0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/swd_xfer_seq.md
# swd_xfer_seq

SWD transfer sequencer sitting directly upstream of the SWD bit-level engine. It accepts one DP/AP register-access command at a time from the command controller over a valid/ready handshake and launches it on the engine with a single-cycle `go` pulse. It collects the engine's ack, read data and parity result, retries WAIT-acknowledged transfers after a back-off, and returns one response per command over a second valid/ready handshake.

## Interface
- `RETRY_W`, 8: width of the retry limit and retry counters.
- `BACKOFF`, 16: clk cycles spent in back-off between a WAIT and the relaunch; must be ≥1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `retry_limit`  in  RETRY_W  maximum relaunches after WAIT; sampled at command accept.
- `abort`  in  1  cancels a pending retry.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_addr32`  in  2  A[3:2].
- `cmd_rnw`  in  1  1 = read.
- `cmd_apndp`  in  1  1 = AP access.
- `cmd_wdata`  in  32  write data.
- `eng_addr32`  out  2  to engine `addr32`.
- `eng_rnw`  out  1  to engine `rnw`.
- `eng_apndp`  out  1  to engine `apndp`.
- `eng_dwrite`  out  32  to engine `dwrite`.
- `eng_go`  out  1  engine trigger.
- `eng_idle`  in  1  engine idle.
- `eng_ack`  in  3  engine ack.
- `eng_dread`  in  32  engine read data.
- `eng_perr`  in  1  engine parity error.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_ack`  out  3  final ack (OK=3'b001, WAIT=3'b010, FAULT=3'b100, else protocol error).
- `rsp_rdata`  out  32  read data; 0 for writes.
- `rsp_perr`  out  1  parity error; always 0 for writes.
- `rsp_retries`  out  RETRY_W  relaunches actually performed.

## Operation
- States: S_IDLE, S_LAUNCH, S_BUSY, S_BACKOFF, S_DONE.
- S_IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&`cmd_ready`: latch the command fields into the `eng_*` holding registers, latch `retry_limit` into `left`, clear `rsp_retries`, go to S_LAUNCH.
- S_LAUNCH:
  - While `eng_idle`=0: wait, with `eng_go`=0.
  - When `eng_idle`=1: drive `eng_go`=1 for exactly this cycle, then go to S_BUSY.
- S_BUSY:
  - The first cycle after launch is ignored, because the engine drops `eng_idle` that cycle.
  - From the second cycle on, when `eng_idle`=1: capture `eng_ack`, `eng_dread` and `eng_perr`, then branch:
    - ack==WAIT and `left`≠0: `left`−1, `rsp_retries`+1, go to S_BACKOFF.
    - Otherwise: go to S_DONE.
- S_BACKOFF:
  - Counter loads BACKOFF−1 on entry and counts down to 0, then goes to S_LAUNCH.
  - `abort`=1 in any S_BACKOFF cycle → S_DONE, with the captured WAIT result.
- S_DONE:
  - `rsp_valid`=1; outputs are held stable until `rsp_ready`=1.
  - On the `rsp_valid`&`rsp_ready` cycle: go to S_IDLE.
- Response data rules:
  - `rsp_rdata` = captured `eng_dread` if read and ack==OK, else 0.
  - `rsp_perr` = captured `eng_perr` & `rnw`.
- `abort` is ignored outside S_BACKOFF.
- `retry_limit`=0 disables retries; WAIT is reported immediately.
- `rsp_retries` saturates naturally, since it is bounded by `left`.

## Timing
- Reset values:
  - State S_IDLE, `cmd_ready`=1, `eng_go`=0, `rsp_valid`=0.
  - `rsp_ack`=0, `rsp_rdata`=0, `rsp_perr`=0, `rsp_retries`=0.
  - `eng_addr32`=0, `eng_rnw`=0, `eng_apndp`=0, `eng_dwrite`=0.
- Reset mid-transfer returns immediately to S_IDLE. Any in-flight command is dropped with no response.
- All outputs are registered.
- Cycle counts, with `eng_idle` high:
  - Accept at cycle N.
  - `eng_go` high at cycle N+1.
  - Engine completion seen (`eng_idle` rising) at cycle M → `rsp_valid` high at M+1.
- WAIT retry: `eng_go` re-asserts BACKOFF+1 cycles after the completion cycle.
- `eng_*` fields stay constant from accept until S_DONE exits, including across retries.
- `eng_go` never asserts while `eng_idle`=0, and never on two consecutive cycles.
- No command is accepted while `rsp_valid`=1; `cmd_ready` and `rsp_valid` are never both 1.
- Combined `abort` and counter expiry in the same cycle: abort wins.

## Configuration
- `SWD_SEQ_STICKY_FAULT_EN` defined:
  - A FAULT ack sets an internal sticky flag.
  - While the flag is set, accepted commands are not launched. They go S_IDLE → S_DONE in one cycle with `rsp_ack`=3'b100 and `rsp_retries`=0.
  - The flag clears on reset or on an accepted write with `cmd_apndp`=0 and `cmd_addr32`=0 (DP ABORT).
- Undefined: no sticky flag; every command is launched.

## Test plan
- Read DP 0, engine returns ack 3'b001, data 0x2BA01477, perr 0 → one `eng_go` pulse; response ack 001, rdata 0x2BA01477, retries 0.
- Write AP 1 data 0xA5A5A5A5, `retry_limit`=3, engine WAIT, WAIT, OK → three `eng_go` pulses, each BACKOFF+1 cycles after the previous completion; response ack 001, retries 2, rdata 0.
- `retry_limit`=2, engine always WAIT → exactly three launches; response ack 010, retries 2.
- `abort` pulsed mid-back-off after the first WAIT → no further launch; response ack 010, retries 1.
- Read with ack OK and perr 1, `rsp_ready` held low for 20 cycles → `rsp_valid` and all fields stable; `cmd_ready`=0 throughout; response rdata equals captured data.
- `rst` asserted in S_BUSY → all outputs at reset values next cycle. With `SWD_SEQ_STICKY_FAULT_EN` defined: FAULT, then a read → completes with no launch and ack 100; a DP ABORT write then launches normally.
